// File: rtl/chip8_pkg.sv
// Shared constants, state type and the built-in hex font for the chip8 memory.
package chip8_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam logic [ADDR_WIDTH-1:0] FONT_BASE = 12'h000;
    localparam logic [ADDR_WIDTH-1:0] PROGRAM_BASE = 12'h200;
    localparam int FONT_BYTES = 80;
    localparam int FONT_IDX_WIDTH = 7;

    // Encoding is fixed: value 3 is unused and steers back to FONT_INIT.
    typedef enum logic [1:0] {
        ST_FONT_INIT = 2'd0,
        ST_LOAD      = 2'd1,
        ST_RUN       = 2'd2
    } mem_state_t;

    // Glyph 0 occupies the most significant bytes; each glyph is 5 rows.
    localparam logic [FONT_BYTES*8-1:0] FONT_TABLE = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
    };

    // Byte idx of the font; indices past the table read as zero.
    function automatic logic [7:0] font_byte(input logic [FONT_IDX_WIDTH-1:0] idx);
        if (int'(idx) < FONT_BYTES) begin
            return FONT_TABLE[(FONT_BYTES - 1 - int'(idx)) * 8 +: 8];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/chip8_font_rom.sv
// Combinational lookup of one byte of the built-in hex font.
module chip8_font_rom
    import chip8_pkg::*;
(
    input  logic [FONT_IDX_WIDTH-1:0] i_index,
    output logic [7:0]                o_data
);

    assign o_data = font_byte(i_index);

endmodule

// File: rtl/chip8_memory.sv
// 4 KiB byte memory for the chip8 core: writes the font after reset, accepts a
// program image from the loader, then releases the core and serves its RAM port.
module chip8_memory
    import chip8_pkg::*;
#(
    parameter int                        P_ADDR_WIDTH   = ADDR_WIDTH,
    parameter logic [P_ADDR_WIDTH-1:0]   P_FONT_BASE    = FONT_BASE,
    parameter int                        P_FONT_BYTES   = FONT_BYTES,
    parameter logic [P_ADDR_WIDTH-1:0]   P_PROGRAM_BASE = PROGRAM_BASE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [P_ADDR_WIDTH-1:0] cpu_address,
    input  logic [7:0]              cpu_data_in,
    input  logic                    cpu_write,
    output logic [7:0]              cpu_data_out,
    output logic                    cpu_run,
    input  logic                    load_valid,
    input  logic [7:0]              load_data,
    input  logic                    load_last,
    input  logic                    load_skip,
    output logic                    load_ready,
    output logic [P_ADDR_WIDTH-1:0] load_count,
    output logic                    load_overflow
);

    localparam int DEPTH = 2 ** P_ADDR_WIDTH;
    localparam logic [P_ADDR_WIDTH-1:0] TOP_ADDR = '1;
    localparam logic [FONT_IDX_WIDTH-1:0] FONT_LAST = FONT_IDX_WIDTH'(P_FONT_BYTES - 1);

    logic [7:0]              r_mem [0:DEPTH-1];
    logic [7:0]              r_cpu_data_out;
    mem_state_t              r_state;
    mem_state_t              w_state_next;
    logic [FONT_IDX_WIDTH-1:0] r_font_idx;
    logic [FONT_IDX_WIDTH-1:0] w_font_idx_next;
    logic [P_ADDR_WIDTH-1:0] r_load_ptr;
    logic [P_ADDR_WIDTH-1:0] w_load_ptr_next;
    logic [P_ADDR_WIDTH-1:0] r_load_count;
    logic [P_ADDR_WIDTH-1:0] w_load_count_next;
    logic                    r_load_overflow;
    logic                    w_load_overflow_next;
    logic                    r_cpu_run;
    logic                    w_load_ready;
    logic                    w_we;
    logic [P_ADDR_WIDTH-1:0] w_waddr;
    logic [7:0]              w_wdata;
    logic [7:0]              w_font_byte;

    chip8_font_rom u_font_rom (
        .i_index (r_font_idx),
        .o_data  (w_font_byte)
    );

    // Next state plus the single write port's source: font, loader or core.
    always_comb begin
        w_state_next         = r_state;
        w_font_idx_next      = r_font_idx;
        w_load_ptr_next      = r_load_ptr;
        w_load_count_next    = r_load_count;
        w_load_overflow_next = r_load_overflow;
        w_load_ready         = 1'b0;
        w_we                 = 1'b0;
        w_waddr              = cpu_address;
        w_wdata              = cpu_data_in;
        case (r_state)
            ST_FONT_INIT: begin
                w_we    = 1'b1;
                w_waddr = P_FONT_BASE + P_ADDR_WIDTH'(r_font_idx);
                w_wdata = w_font_byte;
                if (r_font_idx == FONT_LAST) begin
                    w_font_idx_next = '0;
                    w_state_next    = ST_LOAD;
                end else begin
                    w_font_idx_next = r_font_idx + 1'b1;
                end
            end
            ST_LOAD: begin
                w_load_ready = 1'b1;
                if (load_valid) begin
                    w_we              = 1'b1;
                    w_waddr           = r_load_ptr;
                    w_wdata           = load_data;
                    w_load_count_next = r_load_count + 1'b1;
                    if (r_load_ptr == TOP_ADDR) begin
                        // Pointer saturates: an image that fills memory ends the load.
                        if (!load_last) begin
                            w_load_overflow_next = 1'b1;
                        end
                        w_state_next = ST_RUN;
                    end else begin
                        w_load_ptr_next = r_load_ptr + 1'b1;
                    end
                    if (load_last) begin
                        w_state_next = ST_RUN;
                    end
                end
                if (load_skip) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_we = cpu_write;
            end
            default: begin
                w_state_next    = ST_FONT_INIT;
                w_font_idx_next = '0;
            end
        endcase
    end

    // Control registers; reset aborts any load or run and restarts the font fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_FONT_INIT;
            r_font_idx      <= '0;
            r_load_ptr      <= P_PROGRAM_BASE;
            r_load_count    <= '0;
            r_load_overflow <= 1'b0;
            r_cpu_run       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_font_idx      <= w_font_idx_next;
            r_load_ptr      <= w_load_ptr_next;
            r_load_count    <= w_load_count_next;
            r_load_overflow <= w_load_overflow_next;
            r_cpu_run       <= (r_state == ST_RUN);
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered read of the core address in every state (read-before-write).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cpu_data_out <= 8'h00;
        end else begin
            r_cpu_data_out <= r_mem[cpu_address];
        end
    end

    assign cpu_data_out  = r_cpu_data_out;
    assign cpu_run       = r_cpu_run;
    assign load_ready    = w_load_ready;
    assign load_count    = r_load_count;
    assign load_overflow = r_load_overflow;

endmodule

// File: doc/chip8_memory.md
Name: chip8_memory

Overview:
Byte-wide 4 KiB memory responder serving the chip8 core's RAM port (address, write data, write strobe, read data). After reset it writes the standard 80-byte hex font to 0x000-0x04F. It then accepts a program byte stream on a valid/ready loader port, storing it from 0x200 upward. It holds the core in reset (cpu_run=0) until loading finishes, then serves core reads and writes.

Parameters:
ADDR_WIDTH, 12, byte address width (memory depth = 2**ADDR_WIDTH).
FONT_BASE, 12'h000, first font byte address.
FONT_BYTES, 80, font length (16 glyphs x 5 bytes).
PROGRAM_BASE, 12'h200, first loader byte address.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
cpu_address  input  12  core byte address (core's ram_address_out)
cpu_data_in  input  8  core write data (core's ram_data_out)
cpu_write  input  1  core write strobe, level-sampled each edge
cpu_data_out  output  8  read data to core (core's ram_data_in)
cpu_run  output  1  1 = core may run; drives core reset (active-low)
load_valid  input  1  loader byte valid
load_data  input  8  loader byte
load_last  input  1  qualifies final byte of program, valid with load_valid
load_skip  input  1  single-cycle pulse: end LOAD with no further bytes
load_ready  output  1  loader may transfer
load_count  output  12  bytes accepted since reset
load_overflow  output  1  sticky: image reached top of memory without load_last

Behaviour:
- Reset (async, level): state=FONT_INIT, font index=0, cpu_run=0, load_ready=0, cpu_data_out=0, load_count=0, load_overflow=0, load pointer=PROGRAM_BASE. Memory array is not cleared.
- Reset asserted mid-operation aborts any load or run. The font is rewritten, and previously loaded bytes remain until they are overwritten.
- FONT_INIT:
  - Each edge writes font[idx] to FONT_BASE+idx, then idx++.
  - The edge writing idx=FONT_BYTES-1 moves to LOAD. The font is complete after exactly 80 edges.
  - Core and loader ports are ignored. load_ready=0.
- LOAD:
  - load_ready=1.
  - A transfer occurs on an edge where load_valid&&load_ready. It writes load_data to the pointer, increments the pointer and increments load_count.
  - A transfer with load_last=1 moves to RUN.
  - A transfer at pointer 0xFFF without load_last sets load_overflow=1 and moves to RUN. The pointer does not wrap.
  - load_skip=1 with no transfer on that edge moves to RUN. load_skip together with a transfer: the byte is stored, then the state moves to RUN.
- RUN:
  - load_ready=0, cpu_run=1 (registered, asserted the edge after leaving LOAD).
  - Stays in RUN until reset. Loader inputs are ignored.
- Core read:
  - Synchronous read: on every edge in any state, cpu_data_out <= mem[cpu_address].
  - Data is visible 1 cycle after the address is presented, which meets the core's 2-cycle wait.
- Core write:
  - Only in RUN: if cpu_write=1 at an edge, mem[cpu_address] <= cpu_data_in.
  - A read of the same address on the same edge returns the old data. The new data is visible on the next edge.
  - Writes to the font area are allowed; no protection.
- Widths: pointer and load_count are ADDR_WIDTH bits. The pointer never exceeds 0xFFF, so load_count is at most 0xE00.
- States are encoded in 2 bits: FONT_INIT=0, LOAD=1, RUN=2. Encoding 3 is unreachable and recovers to FONT_INIT.

Decomposition:
- Shared package chip8_pkg holds:
  - ADDR_WIDTH, PROGRAM_BASE, FONT_BASE and FONT_BYTES constants;
  - the memory state enum;
  - the 80-byte font table (0: F0 90 90 90 F0 ... F: F0 80 F0 80 80).
- Sub-module chip8_font_rom: combinational 7-bit index -> 8-bit font byte lookup.
- The memory array stays in chip8_memory, written as an inferable single-port synchronous RAM with write mux.

Test Plan:
- Release reset, hold load_valid=0 -> load_ready rises exactly 80 edges later. Reading addresses 0x000, 0x004, 0x04B and 0x04F returns F0, F0, F0 and 80.
- Stream 4 bytes 6A 05 7A 01, load_last on the fourth -> mem[0x200..0x203] = 6A 05 7A 01, load_count=4, cpu_run=1 the edge after the last transfer, load_ready=0.
- Toggle load_valid with gaps, including valid=1 during FONT_INIT -> no byte stored before LOAD, and only bytes with valid&&ready are stored, in order.
- In RUN: write 3C to 0x300, then read 0x300 -> the write-edge read returns the old value, and the next read returns 3C. The same cpu_write during LOAD leaves memory unchanged.
- Stream 0xE00 bytes without load_last -> load_overflow=1, state RUN, mem[0xFFF] = last byte, mem[0x000] font intact.
- Assert reset mid-LOAD after 2 bytes, then release -> cpu_run=0, load_count=0, font rewritten in 80 edges, and a new load starts at 0x200. load_skip then gives cpu_run=1 with load_count=0.
